mem_stage_cache: RTL and testbench
==================================

MEM_STAGE_CACHE -- requirements
Module: mem_stage_cache

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_b  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: mem_read  in  1  load request; mem_write  in  1  store request; is_LB_SB  in  1  byte access (LB/SB), else word.
REQ-003 SHALL have ports: addr  in  32  byte address (ALU result); store_data  in  32  store operand, byte 0 = bits 7:0.
REQ-004 SHALL have ports: cache_data_out  out  4x8  line bytes [0..3]; mem_block  out  2  byte select = addr[1:0]; freeze  out  1  pipeline stall.
REQ-005 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  32 (word-aligned); mem_wdata  out  32; mem_be  out  4 byte enables.
REQ-006 SHALL have ports: mem_ack  in  1  one-cycle completion pulse; mem_rdata  in  32  fill word, valid with mem_ack.

Function
REQ-007 SHALL implement a direct-mapped cache: 16 lines x 4 bytes, index = addr[5:2], tag = addr[31:6], one valid bit per line.
REQ-008 SHALL use FSM states IDLE, FILL, WRITE; IDLE->FILL on read miss, IDLE->WRITE on any store, FILL/WRITE->IDLE on the cycle mem_ack=1.
REQ-009 On a read hit in IDLE, SHALL drive cache_data_out with the line combinationally, freeze=0, zero-cycle added latency.
REQ-010 On a read miss, SHALL assert freeze combinationally in the same cycle and hold it until the cycle after mem_ack.
REQ-011 In FILL, SHALL hold mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00} until mem_ack; on mem_ack write mem_rdata, tag, valid=1.
REQ-012 After a fill, the held read SHALL hit in the next IDLE cycle; read-miss penalty = memory latency + 1 cycle.
REQ-013 Stores SHALL be write-through, no-write-allocate; freeze=1 from store entry until the cycle after mem_ack.
REQ-014 In WRITE, mem_we=1; SB: mem_be one-hot at addr[1:0], store_data[7:0] replicated to all lanes; SW: mem_be=4'b1111, addr[1:0] ignored.
REQ-015 On a store hit, SHALL update only enabled bytes of the line, on the mem_ack cycle; a store miss SHALL leave the cache unchanged.
REQ-016 mem_read and mem_write both 1 SHALL be treated as a store.
REQ-017 When neither request is active, or during a miss, cache_data_out SHALL be all zero.
REQ-018 mem_ack in IDLE SHALL be ignored; inputs are held stable by upstream while freeze=1.

Reset
REQ-019 rst_b=0 SHALL immediately force FSM=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_be=0, freeze=0, counters=0.
REQ-020 Reset mid-FILL/WRITE SHALL abandon the transaction; a late mem_ack after reset SHALL be ignored.
REQ-021 Line data and tags SHALL need no reset.

Configuration
REQ-022 With CACHE_STATS_EN defined, SHALL add outputs hit_count/miss_count (32 each), incremented once per completed read hit/read miss, wrap at 2^32.
REQ-023 Without CACHE_STATS_EN, these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-024 Shared package SHALL hold the FSM state enum, CACHE_LINES=16, INDEX_W=4, TAG_W=26.
REQ-025 Tag/valid/data storage SHALL be one sub-module, cache_line_array (read async, write sync, per-byte enables, valid clear on reset).

Verification
REQ-026 Reset, LB 0x0000_0010 with 3-cycle ack, mem_rdata=0x4433_2211 -> freeze high 4 cycles, then cache_data_out={11,22,33,44}, mem_block=0.
REQ-027 Repeat LB 0x0000_0013 -> hit, freeze=0 same cycle, mem_block=3, no mem_req.
REQ-028 SB 0x0000_0012 data 0xAB -> mem_be=4'b0100, mem_wdata=0xABABABAB; next LB reads line {11,22,AB,44}.
REQ-029 SW miss at 0x0000_0100 -> memory write issued, line 0 index unchanged; following LW 0x0000_0100 misses.
REQ-030 Alias: load 0x0000_0010 then 0x0000_0050 (same index) -> second misses, refill replaces tag; 0x10 then misses again.
REQ-031 rst_b low during FILL, then mem_ack pulse -> FSM IDLE, freeze=0, no valid line set.

Source files
------------

// File: rtl/mem_stage_cache_pkg.sv
// mem_stage_cache_pkg: shared FSM encoding and cache geometry for the MEM-stage cache
// No ports; imported by cache_line_array and mem_stage_cache.
package mem_stage_cache_pkg;
    localparam int CACHE_LINES = 16;
    localparam int INDEX_W     = 4;
    localparam int TAG_W       = 26;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, WRITE = 2'd2} state_t;
endpackage

// File: rtl/mem_stage_cache_line_array.sv
// cache_line_array: tag/valid/data storage, async read, sync write with per-byte enables
// Ports:
//   clk, rst_b                  clock, async active-low reset (clears valid bits only)
//   rd_index -> rd_tag/valid/data  combinational lookup
//   wr_index, wr_be, wr_data    byte-enabled line write
//   wr_fill, wr_tag             refill: also loads the tag and sets valid
import mem_stage_cache_pkg::*;

module cache_line_array (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic [TAG_W-1:0]     rd_tag,
    output logic                 rd_valid,
    output logic [3:0][7:0]      rd_data,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [3:0]           wr_be,
    input  logic [3:0][7:0]      wr_data,
    input  logic                 wr_fill,
    input  logic [TAG_W-1:0]     wr_tag
);
    logic [TAG_W-1:0]       tags  [CACHE_LINES];
    logic [3:0][7:0]        lines [CACHE_LINES];
    logic [CACHE_LINES-1:0] valid;
    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_data  = lines[rd_index];
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b)
            valid <= '0;
        else if (wr_fill)
            valid[wr_index] <= 1'b1;
    always_ff @(posedge clk) begin
        if (wr_fill)
            tags[wr_index] <= wr_tag;
        for (int b = 0; b < 4; b++)
            if (wr_be[b])
                lines[wr_index][b] <= wr_data[b];
    end
endmodule

// File: rtl/mem_stage_cache.sv
// mem_stage_cache: direct-mapped 16x4B write-through, no-write-allocate MEM-stage cache
// Ports:
//   clk, rst_b                        clock, async active-low reset
//   mem_read, mem_write, is_LB_SB     load/store request, byte vs word access
//   addr, store_data                  byte address, store operand
//   cache_data_out, mem_block         hit line bytes [0..3], byte select addr[1:0]
//   freeze                            pipeline stall during miss/store
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_be                 backing memory request
//   mem_ack, mem_rdata                memory completion pulse, fill word
//   hit_count, miss_count             only when CACHE_STATS_EN is defined
import mem_stage_cache_pkg::*;

module mem_stage_cache (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            is_LB_SB,
    input  logic [31:0]     addr,
    input  logic [31:0]     store_data,
    output logic [3:0][7:0] cache_data_out,
    output logic [1:0]      mem_block,
    output logic            freeze,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);
    state_t          state, state_nxt;
    logic [TAG_W-1:0] line_tag;
    logic            line_valid, hit, store, load, fill_done, store_hit;
    logic [3:0][7:0] line_data;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    // a simultaneous read+write request is a store
    assign store     = mem_write;
    assign load      = mem_read & ~mem_write;
    assign hit       = line_valid && line_tag == addr[31:6];
    assign fill_done = state == FILL && mem_ack;
    assign store_hit = state == WRITE && mem_ack && hit;
    always_comb
        state_nxt = state == IDLE ? (store ? WRITE : (load && !hit) ? FILL : IDLE)
                                  : (mem_ack ? IDLE : state);
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b)
            state <= IDLE;
        else
            state <= state_nxt;
    // stall is combinational so the miss cycle itself already freezes the pipe
    assign freeze         = rst_b && (state != IDLE || store || (load && !hit));
    assign mem_req        = state != IDLE;
    assign mem_we         = state == WRITE;
    assign mem_addr       = {addr[31:2], 2'b00};
    assign mem_wdata      = is_LB_SB ? {4{store_data[7:0]}} : store_data;
    assign mem_be         = state != WRITE ? 4'b0000 : is_LB_SB ? 4'b0001 << addr[1:0] : 4'b1111;
    assign mem_block      = addr[1:0];
    assign cache_data_out = (state == IDLE && load && hit) ? line_data : '0;
    assign wr_be          = fill_done ? 4'b1111 : store_hit ? mem_be : 4'b0000;
    assign wr_data        = fill_done ? mem_rdata : mem_wdata;
    cache_line_array u_lines (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_index (addr[5:2]),
        .rd_tag   (line_tag),
        .rd_valid (line_valid),
        .rd_data  (line_data),
        .wr_index (addr[5:2]),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_fill  (fill_done),
        .wr_tag   (addr[31:6])
    );
`ifdef CACHE_STATS_EN
    // the held load hits right after its refill; that retry belongs to the miss, not a new hit
    logic refilled;
    always_ff @(posedge clk or negedge rst_b)
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
            refilled   <= 1'b0;
        end else begin
            refilled <= fill_done;
            if (fill_done)
                miss_count <= miss_count + 32'd1;
            if (state == IDLE && load && hit && !refilled)
                hit_count <= hit_count + 32'd1;
        end
`endif
endmodule

// File: tb/tb_mem_stage_cache.sv
// tb_mem_stage_cache: directed table plus randomized checks against a line-level cache model
module tb_mem_stage_cache;
    logic            clk = 0, rst_b = 0;
    logic            mem_read = 0, mem_write = 0, is_LB_SB = 0, mem_ack = 0;
    logic [31:0]     addr = 0, store_data = 0, mem_rdata = 0;
    logic [3:0][7:0] cache_data_out;
    logic [1:0]      mem_block;
    logic            freeze, mem_req, mem_we;
    logic [31:0]     mem_addr, mem_wdata;
    logic [3:0]      mem_be;
    int              n_chk = 0, n_fail = 0;
    logic            m_valid [16];
    logic [25:0]     m_tag   [16];
    logic [31:0]     m_data  [16];

    typedef struct {
        logic        r, w, lb;
        logic [31:0] a, sd;
        int          lat;
        logic [31:0] rd;
        logic        e_miss;
        logic [31:0] e_data;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;
    vec_t tv [12];

    always #5 clk = ~clk;

    mem_stage_cache dut (
        .clk(clk), .rst_b(rst_b), .mem_read(mem_read), .mem_write(mem_write),
        .is_LB_SB(is_LB_SB), .addr(addr), .store_data(store_data),
        .cache_data_out(cache_data_out), .mem_block(mem_block), .freeze(freeze),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    // one request from entry to completion; starts and ends 1 time unit after a rising edge
    task automatic access(input logic r, w, lb, input logic [31:0] a, sd, input int lat,
                          input logic [31:0] rd, output logic g_miss, output logic [31:0] g_data,
                          output logic [3:0] g_be, output logic [31:0] g_wd);
        logic st, ld, hit;
        logic [3:0]  idx, e_be;
        logic [31:0] e_wd;
        st = w;
        ld = r & ~w;
        idx = a[5:2];
        hit = m_valid[idx] && m_tag[idx] == a[31:6];
        e_be = lb ? 4'(1 << a[1:0]) : 4'hf;
        e_wd = lb ? {4{sd[7:0]}} : sd;
        g_be = 0;
        g_wd = 0;
        mem_read = r; mem_write = w; is_LB_SB = lb; addr = a; store_data = sd; mem_ack = 0;
        #4;
        g_miss = freeze;
        g_data = cache_data_out;
        if (!st && !ld) begin
            chk("idle_freeze", 32'(freeze), 0);
            chk("idle_data", cache_data_out, 0);
            chk("idle_req", 32'(mem_req), 0);
            @(posedge clk); #1;
            return;
        end
        if (ld && hit) begin
            chk("hit_freeze", 32'(freeze), 0);
            chk("hit_data", cache_data_out, m_data[idx]);
            chk("hit_req", 32'(mem_req), 0);
            chk("hit_block", 32'(mem_block), 32'(a[1:0]));
            @(posedge clk); #1;
            return;
        end
        chk("entry_freeze", 32'(freeze), 1);
        chk("entry_data", cache_data_out, 0);
        @(posedge clk); #1;
        for (int i = 1; i <= lat; i++) begin
            mem_ack = (i == lat);
            mem_rdata = rd;
            #4;
            chk("busy_req", 32'(mem_req), 1);
            chk("busy_we", 32'(mem_we), 32'(st));
            chk("busy_addr", mem_addr, {a[31:2], 2'b00});
            chk("busy_freeze", 32'(freeze), 1);
            chk("busy_data", cache_data_out, 0);
            if (st) begin
                chk("wr_be", 32'(mem_be), 32'(e_be));
                chk("wr_wdata", mem_wdata, e_wd);
                if (i == 1) begin
                    g_be = mem_be;
                    g_wd = mem_wdata;
                end
            end
            @(posedge clk); #1;
        end
        mem_ack = 0;
        if (ld) begin
            m_valid[idx] = 1;
            m_tag[idx] = a[31:6];
            m_data[idx] = rd;
            #4;
            chk("refill_freeze", 32'(freeze), 0);
            chk("refill_data", cache_data_out, rd);
            chk("refill_req", 32'(mem_req), 0);
            chk("refill_block", 32'(mem_block), 32'(a[1:0]));
            g_data = cache_data_out;
        end else begin
            if (hit)
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) m_data[idx][8*b +: 8] = e_wd[8*b +: 8];
            mem_read = 0;
            mem_write = 0;
            #4;
            chk("post_wr_freeze", 32'(freeze), 0);
            chk("post_wr_req", 32'(mem_req), 0);
            g_data = cache_data_out;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic        g_miss;
        logic [31:0] g_data, g_wd;
        logic [3:0]  g_be;
        tv[0]  = '{1, 0, 1, 32'h10,  32'h0,        3, 32'h44332211, 1, 32'h44332211, 4'h0,    32'h0};
        tv[1]  = '{1, 0, 1, 32'h13,  32'h0,        1, 32'h0,        0, 32'h44332211, 4'h0,    32'h0};
        tv[2]  = '{0, 1, 1, 32'h12,  32'hAB,       2, 32'h0,        1, 32'h0,        4'b0100, 32'hABABABAB};
        tv[3]  = '{1, 0, 1, 32'h10,  32'h0,        1, 32'h0,        0, 32'h44AB2211, 4'h0,    32'h0};
        tv[4]  = '{0, 1, 0, 32'h100, 32'hDEADBEEF, 2, 32'h0,        1, 32'h0,        4'hf,    32'hDEADBEEF};
        tv[5]  = '{1, 0, 1, 32'h10,  32'h0,        1, 32'h0,        0, 32'h44AB2211, 4'h0,    32'h0};
        tv[6]  = '{1, 0, 0, 32'h100, 32'h0,        1, 32'h12345678, 1, 32'h12345678, 4'h0,    32'h0};
        tv[7]  = '{1, 0, 0, 32'h50,  32'h0,        2, 32'h88776655, 1, 32'h88776655, 4'h0,    32'h0};
        tv[8]  = '{1, 0, 0, 32'h10,  32'h0,        1, 32'h44AB2211, 1, 32'h44AB2211, 4'h0,    32'h0};
        tv[9]  = '{0, 0, 0, 32'h10,  32'h0,        1, 32'h0,        0, 32'h0,        4'h0,    32'h0};
        tv[10] = '{1, 1, 0, 32'h10,  32'h01020304, 1, 32'h0,        1, 32'h0,        4'hf,    32'h01020304};
        tv[11] = '{1, 0, 0, 32'h10,  32'h0,        1, 32'h0,        0, 32'h01020304, 4'h0,    32'h0};
        m_clear();
        #1;
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_be", 32'(mem_be), 0);
        chk("rst_data", cache_data_out, 0);
        @(posedge clk); #1;
        rst_b = 1;
        for (int i = 0; i < 12; i++) begin
            access(tv[i].r, tv[i].w, tv[i].lb, tv[i].a, tv[i].sd, tv[i].lat, tv[i].rd,
                   g_miss, g_data, g_be, g_wd);
            chk($sformatf("tv%0d_miss", i), 32'(g_miss), 32'(tv[i].e_miss));
            chk($sformatf("tv%0d_data", i), g_data, tv[i].e_data);
            chk($sformatf("tv%0d_be", i), 32'(g_be), 32'(tv[i].e_be));
            chk($sformatf("tv%0d_wdata", i), g_wd, tv[i].e_wd);
        end
        // reset in the middle of a refill, then a stray ack
        mem_read = 1; mem_write = 0; is_LB_SB = 1; addr = 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("midfill_req", 32'(mem_req), 1);
        rst_b = 0;
        #1;
        chk("rstfill_freeze", 32'(freeze), 0);
        chk("rstfill_req", 32'(mem_req), 0);
        chk("rstfill_we", 32'(mem_we), 0);
        chk("rstfill_be", 32'(mem_be), 0);
        mem_read = 0;
        m_clear();
        @(posedge clk); #1;
        rst_b = 1;
        mem_ack = 1;
        mem_rdata = 32'hCAFEF00D;
        #4;
        chk("late_ack_freeze", 32'(freeze), 0);
        chk("late_ack_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        mem_ack = 0;
        #4;
        chk("after_ack_req", 32'(mem_req), 0);
        @(posedge clk); #1;
        access(1, 0, 1, 32'h20, 0, 2, 32'h55667788, g_miss, g_data, g_be, g_wd);
        chk("rst_inval_20", 32'(g_miss), 1);
        access(1, 0, 0, 32'h10, 0, 1, 32'h0BADBEEF, g_miss, g_data, g_be, g_wd);
        chk("rst_inval_10", 32'(g_miss), 1);
        for (int n = 0; n < 400; n++) begin
            int k;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            access(k < 5 || k == 8, k >= 5 && k <= 8, 1'($urandom_range(0, 1)), a, $urandom,
                   $urandom_range(1, 4), $urandom, g_miss, g_data, g_be, g_wd);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
